// File: rtl/axi_boot_loader.sv
// -----------------------------------------------------------------------------
// axi_boot_loader
//   Boot stage that sits in front of the CPU and its program SRAM. It takes a
//   byte stream, assembles little-endian 32-bit words, writes them one at a
//   time over AXI4-Lite into SRAM starting at BASE_ADDR, and holds the CPU in
//   reset until the whole image has been written.
//
//   Stream format: 16-bit word count N (LSB first), then N*4 data bytes, with
//   each word sent LSB first.
//
// Ports
//   clk, resetn              clock, asynchronous active-low reset
//   s_byte_valid/ready/data  byte stream input (valid/ready handshake)
//   m_axi_aw*                AXI4-Lite write address channel (master)
//   m_axi_w*                 AXI4-Lite write data channel (master)
//   m_axi_b*                 AXI4-Lite write response channel (master)
//   cpu_resetn               active-low CPU reset, released once the image is loaded
//   boot_done                image loaded, CPU released
//   boot_error               load aborted (bad length or error response)
//   words_written            number of words that completed with OKAY
// -----------------------------------------------------------------------------
module axi_boot_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 512,
    parameter int          CNT_W     = 10
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             s_byte_valid,
    output logic             s_byte_ready,
    input  logic [7:0]       s_byte_data,
    output logic             m_axi_awvalid,
    input  logic             m_axi_awready,
    output logic [31:0]      m_axi_awaddr,
    output logic [2:0]       m_axi_awprot,
    output logic             m_axi_wvalid,
    input  logic             m_axi_wready,
    output logic [31:0]      m_axi_wdata,
    output logic [3:0]       m_axi_wstrb,
    input  logic             m_axi_bvalid,
    output logic             m_axi_bready,
    input  logic [1:0]       m_axi_bresp,
    output logic             cpu_resetn,
    output logic             boot_done,
    output logic             boot_error,
    output logic [CNT_W-1:0] words_written
);

    typedef enum logic [2:0] {
        ST_HDR0    = 3'd0,
        ST_HDR1    = 3'd1,
        ST_COLLECT = 3'd2,
        ST_WRITE   = 3'd3,
        ST_RESP    = 3'd4,
        ST_DONE    = 3'd5,
        ST_ERROR   = 3'd6
    } state_t;

    state_t             r_state;
    state_t             w_next_state;

    logic [15:0]        r_n;
    logic [CNT_W-1:0]   r_idx;
    logic [1:0]         r_byte_cnt;
    logic [31:0]        r_word;
    logic               r_byte_ready;
    logic               r_awvalid;
    logic               r_wvalid;
    logic               r_bready;
    logic [31:0]        r_awaddr;
    logic [31:0]        r_wdata;
    logic               r_cpu_resetn;
    logic               r_boot_done;
    logic               r_boot_error;
    logic [CNT_W-1:0]   r_words_written;

    logic               w_byte_acc;
    logic               w_aw_fin;
    logic               w_w_fin;
    logic               w_b_hs;
    logic [15:0]        w_hdr_n;
    logic [CNT_W-1:0]   w_idx_inc;
    logic               w_last;
    logic               w_next_accepts;

    // r_byte_ready is only ever high in the byte-accepting states, so the
    // handshake alone identifies an accepted byte.
    assign w_byte_acc = s_byte_valid & r_byte_ready;
    // A channel is finished once its valid has dropped or is handshaking now.
    assign w_aw_fin   = ~r_awvalid | m_axi_awready;
    assign w_w_fin    = ~r_wvalid  | m_axi_wready;
    assign w_b_hs     = m_axi_bvalid & r_bready;
    assign w_hdr_n    = {s_byte_data, r_n[7:0]};
    assign w_idx_inc  = r_idx + CNT_W'(1);
    assign w_last     = ({{(16-CNT_W){1'b0}}, w_idx_inc} == r_n);

    // Next-state decode for the load sequencer.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_HDR0: begin
                if (w_byte_acc) begin
                    w_next_state = ST_HDR1;
                end else begin
                    w_next_state = r_state;
                end
            end
            ST_HDR1: begin
                if (!w_byte_acc) begin
                    w_next_state = r_state;
                end else if (w_hdr_n == 16'h0000) begin
                    w_next_state = ST_DONE;
                end else if (w_hdr_n > 16'(MAX_WORDS)) begin
                    w_next_state = ST_ERROR;
                end else begin
                    w_next_state = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (w_byte_acc && (r_byte_cnt == 2'd3)) begin
                    w_next_state = ST_WRITE;
                end else begin
                    w_next_state = r_state;
                end
            end
            ST_WRITE: begin
                if (w_aw_fin && w_w_fin) begin
                    w_next_state = ST_RESP;
                end else begin
                    w_next_state = r_state;
                end
            end
            ST_RESP: begin
                if (!w_b_hs) begin
                    w_next_state = r_state;
                end else if (m_axi_bresp != 2'b00) begin
                    w_next_state = ST_ERROR;
                end else if (w_last) begin
                    w_next_state = ST_DONE;
                end else begin
                    w_next_state = ST_COLLECT;
                end
            end
            ST_DONE:  w_next_state = ST_DONE;
            ST_ERROR: w_next_state = ST_ERROR;
            default:  w_next_state = ST_HDR0;
        endcase
    end

    // Byte ready is registered from the next state, so it can never be high
    // in the same cycle as a B handshake.
    always_comb begin
        w_next_accepts = 1'b0;
        case (w_next_state)
            ST_HDR0, ST_HDR1, ST_COLLECT: w_next_accepts = 1'b1;
            default:                      w_next_accepts = 1'b0;
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_HDR0;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Handshake/status outputs derived from the state.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_byte_ready <= 1'b0;
            r_bready     <= 1'b0;
            r_boot_done  <= 1'b0;
            r_cpu_resetn <= 1'b0;
            r_boot_error <= 1'b0;
        end else begin
            r_byte_ready <= w_next_accepts;
            r_bready     <= (w_next_state == ST_RESP);
            r_boot_done  <= (r_state == ST_DONE);
            r_cpu_resetn <= (r_state == ST_DONE);
            r_boot_error <= (r_state == ST_ERROR);
        end
    end

    // Datapath: header length, word assembly, AXI address/data and counters.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_n             <= 16'h0000;
            r_idx           <= '0;
            r_byte_cnt      <= 2'd0;
            r_word          <= 32'h0000_0000;
            r_awvalid       <= 1'b0;
            r_wvalid        <= 1'b0;
            r_awaddr        <= 32'h0000_0000;
            r_wdata         <= 32'h0000_0000;
            r_words_written <= '0;
        end else begin
            case (r_state)
                ST_HDR0: begin
                    if (w_byte_acc) begin
                        r_n[7:0] <= s_byte_data;
                    end
                end
                ST_HDR1: begin
                    if (w_byte_acc) begin
                        r_n[15:8]  <= s_byte_data;
                        r_idx      <= '0;
                        r_byte_cnt <= 2'd0;
                    end
                end
                ST_COLLECT: begin
                    if (w_byte_acc) begin
                        r_word[{r_byte_cnt, 3'b000} +: 8] <= s_byte_data;
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        if (r_byte_cnt == 2'd3) begin
                            // Address wraps modulo 2^32 by construction.
                            r_awaddr  <= BASE_ADDR + (32'(r_idx) << 2);
                            r_wdata   <= {s_byte_data, r_word[23:0]};
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                        end
                    end
                end
                ST_WRITE: begin
                    if (r_awvalid && m_axi_awready) begin
                        r_awvalid <= 1'b0;
                    end
                    if (r_wvalid && m_axi_wready) begin
                        r_wvalid <= 1'b0;
                    end
                end
                ST_RESP: begin
                    if (w_b_hs && (m_axi_bresp == 2'b00)) begin
                        r_idx           <= w_idx_inc;
                        r_words_written <= r_words_written + CNT_W'(1);
                    end
                end
                default: begin
                    r_awvalid <= 1'b0;
                    r_wvalid  <= 1'b0;
                end
            endcase
        end
    end

    assign s_byte_ready  = r_byte_ready;
    assign m_axi_awvalid = r_awvalid;
    assign m_axi_awaddr  = r_awaddr;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_wvalid  = r_wvalid;
    assign m_axi_wdata   = r_wdata;
    assign m_axi_wstrb   = 4'hF;
    assign m_axi_bready  = r_bready;
    assign cpu_resetn    = r_cpu_resetn;
    assign boot_done     = r_boot_done;
    assign boot_error    = r_boot_error;
    assign words_written = r_words_written;

endmodule

// File: tb/tb_axi_boot_loader.sv
// -----------------------------------------------------------------------------
// tb_axi_boot_loader
//   Directed bench for axi_boot_loader. A small AXI4-Lite slave model records
//   every AW/W handshake, checks address/data stability while valid is held,
//   and returns B responses (optionally an error on a chosen word).
// -----------------------------------------------------------------------------
module tb_axi_boot_loader;

    localparam int CNT_W = 10;

    logic             clk;
    logic             resetn;
    logic             s_byte_valid;
    logic             s_byte_ready;
    logic [7:0]       s_byte_data;
    logic             m_axi_awvalid;
    logic             m_axi_awready;
    logic [31:0]      m_axi_awaddr;
    logic [2:0]       m_axi_awprot;
    logic             m_axi_wvalid;
    logic             m_axi_wready;
    logic [31:0]      m_axi_wdata;
    logic [3:0]       m_axi_wstrb;
    logic             m_axi_bvalid;
    logic             m_axi_bready;
    logic [1:0]       m_axi_bresp;
    logic             cpu_resetn;
    logic             boot_done;
    logic             boot_error;
    logic [CNT_W-1:0] words_written;

    int checks = 0;
    int errors = 0;

    // slave model state
    logic [31:0] aw_q[$];
    logic [31:0] w_q[$];
    int          aw_delay = 0;
    int          w_delay  = 0;
    int          err_word = -1;
    int          aw_cnt, w_cnt, b_cnt;
    logic        b_fire;
    logic        aw_pend, w_pend;
    logic [31:0] aw_prev, w_prev;

    axi_boot_loader #(
        .BASE_ADDR(32'h0000_0000),
        .MAX_WORDS(512),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .s_byte_valid(s_byte_valid),
        .s_byte_ready(s_byte_ready),
        .s_byte_data(s_byte_data),
        .m_axi_awvalid(m_axi_awvalid),
        .m_axi_awready(m_axi_awready),
        .m_axi_awaddr(m_axi_awaddr),
        .m_axi_awprot(m_axi_awprot),
        .m_axi_wvalid(m_axi_wvalid),
        .m_axi_wready(m_axi_wready),
        .m_axi_wdata(m_axi_wdata),
        .m_axi_wstrb(m_axi_wstrb),
        .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bready(m_axi_bready),
        .m_axi_bresp(m_axi_bresp),
        .cpu_resetn(cpu_resetn),
        .boot_done(boot_done),
        .boot_error(boot_error),
        .words_written(words_written)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // AXI-Lite slave model; everything happens on the falling edge so the
    // values seen here are the ones the DUT samples on the next rising edge.
    always @(negedge clk) begin
        if (!resetn) begin
            m_axi_awready = 1'b0;
            m_axi_wready  = 1'b0;
            m_axi_bvalid  = 1'b0;
            m_axi_bresp   = 2'b00;
            aw_cnt = 0; w_cnt = 0; b_cnt = 0;
            b_fire = 1'b0; aw_pend = 1'b0; w_pend = 1'b0;
        end else begin
            if (b_fire) begin
                m_axi_bvalid = 1'b0;
                b_fire = 1'b0;
                b_cnt++;
            end
            if (!m_axi_bvalid && (aw_q.size() > b_cnt) && (w_q.size() > b_cnt)) begin
                m_axi_bvalid = 1'b1;
                m_axi_bresp  = (b_cnt == err_word) ? 2'b10 : 2'b00;
            end
            b_fire = m_axi_bvalid && m_axi_bready;

            if (aw_pend) begin
                checks++;
                if (!m_axi_awvalid || (m_axi_awaddr !== aw_prev)) begin
                    errors++;
                    $display("FAIL aw_stable: valid=%0b addr=%h required held addr=%h", m_axi_awvalid, m_axi_awaddr, aw_prev);
                end
            end
            if (w_pend) begin
                checks++;
                if (!m_axi_wvalid || (m_axi_wdata !== w_prev)) begin
                    errors++;
                    $display("FAIL w_stable: valid=%0b data=%h required held data=%h", m_axi_wvalid, m_axi_wdata, w_prev);
                end
            end

            if (m_axi_awvalid) begin
                if (aw_cnt >= aw_delay) m_axi_awready = 1'b1;
                else begin m_axi_awready = 1'b0; aw_cnt++; end
            end else begin
                m_axi_awready = 1'b0; aw_cnt = 0;
            end
            if (m_axi_wvalid) begin
                if (w_cnt >= w_delay) m_axi_wready = 1'b1;
                else begin m_axi_wready = 1'b0; w_cnt++; end
            end else begin
                m_axi_wready = 1'b0; w_cnt = 0;
            end

            if (m_axi_awvalid && m_axi_awready) begin
                aw_q.push_back(m_axi_awaddr); aw_pend = 1'b0; aw_cnt = 0;
            end else if (m_axi_awvalid) begin
                aw_pend = 1'b1; aw_prev = m_axi_awaddr;
            end else begin
                aw_pend = 1'b0;
            end
            if (m_axi_wvalid && m_axi_wready) begin
                w_q.push_back(m_axi_wdata); w_pend = 1'b0; w_cnt = 0;
            end else if (m_axi_wvalid) begin
                w_pend = 1'b1; w_prev = m_axi_wdata;
            end else begin
                w_pend = 1'b0;
            end
        end
    end

    // Reset the DUT and the slave model; returns on a falling edge.
    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0;
        s_byte_valid = 1'b0;
        @(posedge clk);
        aw_q.delete();
        w_q.delete();
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
    endtask

    // Offer one byte, wait (bounded) for acceptance; called on a falling edge.
    task automatic send_byte(input logic [7:0] b);
        int t;
        s_byte_valid = 1'b1;
        s_byte_data  = b;
        t = 0;
        while (!s_byte_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (t >= 300) begin
            errors++;
            $display("FAIL byte_accept: byte %h not accepted within 300 cycles, required accepted", b);
        end
        @(negedge clk);
        s_byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[7:0]);
        send_byte(w[15:8]);
        send_byte(w[23:16]);
        send_byte(w[31:24]);
    endtask

    task automatic wait_end();
        int t;
        t = 0;
        while (!boot_done && !boot_error && t < 2000) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (t >= 2000) begin
            errors++;
            $display("FAIL wait_end: no boot_done/boot_error within 2000 cycles");
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        checks++;
        if ({cpu_resetn, s_byte_ready, m_axi_awvalid, m_axi_wvalid, m_axi_bready, boot_done, boot_error} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctrl: cpu_rstn/rdy/awv/wv/bready/done/err=%b required 0000000",
                     {cpu_resetn, s_byte_ready, m_axi_awvalid, m_axi_wvalid, m_axi_bready, boot_done, boot_error});
        end
        checks++;
        if (m_axi_awaddr !== 32'h0 || m_axi_wdata !== 32'h0 || words_written !== 10'd0) begin
            errors++;
            $display("FAIL reset_data: awaddr=%h wdata=%h ww=%0d required 0", m_axi_awaddr, m_axi_wdata, words_written);
        end
        checks++;
        if (m_axi_awprot !== 3'b000 || m_axi_wstrb !== 4'hF) begin
            errors++;
            $display("FAIL tie_offs: awprot=%b wstrb=%h required 000/f", m_axi_awprot, m_axi_wstrb);
        end
        do_reset();
    endtask

    task automatic test_image3(input int awd, input int wd);
        logic [31:0] exp_d[3];
        exp_d[0] = 32'h1122_3344;
        exp_d[1] = 32'hDEAD_BEEF;
        exp_d[2] = 32'h0000_0013;
        do_reset();
        aw_delay = awd;
        w_delay  = wd;
        send_byte(8'h03);
        send_byte(8'h00);
        for (int i = 0; i < 3; i++) send_word(exp_d[i]);
        wait_end();
        checks++;
        if (aw_q.size() != 3 || w_q.size() != 3) begin
            errors++;
            $display("FAIL img3_count(aw=%0d,w=%0d): aw=%0d w=%0d writes required 3", awd, wd, aw_q.size(), w_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (aw_q[i] !== 32'(i * 4) || w_q[i] !== exp_d[i]) begin
                    errors++;
                    $display("FAIL img3_write%0d(aw=%0d,w=%0d): addr=%h data=%h required addr=%h data=%h",
                             i, awd, wd, aw_q[i], w_q[i], 32'(i * 4), exp_d[i]);
                end
            end
        end
        checks++;
        if (words_written !== 10'd3 || boot_done !== 1'b1 || cpu_resetn !== 1'b1 || boot_error !== 1'b0) begin
            errors++;
            $display("FAIL img3_status(aw=%0d,w=%0d): ww=%0d done=%b cpu_rstn=%b err=%b required 3/1/1/0",
                     awd, wd, words_written, boot_done, cpu_resetn, boot_error);
        end
        aw_delay = 0;
        w_delay  = 0;
    endtask

    task automatic test_zero_header();
        do_reset();
        send_byte(8'h00);
        send_byte(8'h00);
        checks++;
        if (boot_done !== 1'b0) begin
            errors++;
            $display("FAIL zero_done_early: boot_done=%b one cycle after 2nd byte, required 0", boot_done);
        end
        @(negedge clk);
        checks++;
        if (boot_done !== 1'b1 || cpu_resetn !== 1'b1 || s_byte_ready !== 1'b0) begin
            errors++;
            $display("FAIL zero_done: done=%b cpu_rstn=%b rdy=%b required 1/1/0", boot_done, cpu_resetn, s_byte_ready);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (aw_q.size() != 0 || w_q.size() != 0 || m_axi_awvalid !== 1'b0 || m_axi_wvalid !== 1'b0) begin
            errors++;
            $display("FAIL zero_axi: aw=%0d w=%0d writes, awv=%b wv=%b required none", aw_q.size(), w_q.size(), m_axi_awvalid, m_axi_wvalid);
        end
    endtask

    task automatic test_too_big();
        do_reset();
        send_byte(8'h01);
        send_byte(8'h02);
        repeat (3) @(negedge clk);
        checks++;
        if (boot_error !== 1'b1 || cpu_resetn !== 1'b0 || s_byte_ready !== 1'b0 || boot_done !== 1'b0) begin
            errors++;
            $display("FAIL too_big: err=%b cpu_rstn=%b rdy=%b done=%b required 1/0/0/0", boot_error, cpu_resetn, s_byte_ready, boot_done);
        end
        checks++;
        if (aw_q.size() != 0 || w_q.size() != 0 || m_axi_awvalid !== 1'b0) begin
            errors++;
            $display("FAIL too_big_axi: aw=%0d w=%0d writes awv=%b required none", aw_q.size(), w_q.size(), m_axi_awvalid);
        end
    endtask

    task automatic test_bresp_error();
        do_reset();
        err_word = 2;
        send_byte(8'h04);
        send_byte(8'h00);
        send_word(32'h0000_0001);
        send_word(32'h0000_0002);
        send_word(32'h0000_0003);
        wait_end();
        checks++;
        if (boot_error !== 1'b1 || words_written !== 10'd2 || cpu_resetn !== 1'b0 || boot_done !== 1'b0) begin
            errors++;
            $display("FAIL bresp_err: err=%b ww=%0d cpu_rstn=%b done=%b required 1/2/0/0", boot_error, words_written, cpu_resetn, boot_done);
        end
        checks++;
        if (s_byte_ready !== 1'b0) begin
            errors++;
            $display("FAIL bresp_err_rdy: s_byte_ready=%b required 0", s_byte_ready);
        end
        err_word = -1;
    endtask

    task automatic test_reset_midload();
        do_reset();
        send_byte(8'h02);
        send_byte(8'h00);
        send_word(32'h1234_5678);
        send_byte(8'hAA);
        do_reset();
        send_byte(8'h01);
        send_byte(8'h00);
        send_word(32'hCAFE_F00D);
        wait_end();
        checks++;
        if (aw_q.size() != 1 || w_q.size() != 1) begin
            errors++;
            $display("FAIL midload_count: aw=%0d w=%0d writes required 1", aw_q.size(), w_q.size());
        end else begin
            checks++;
            if (aw_q[0] !== 32'h0 || w_q[0] !== 32'hCAFE_F00D) begin
                errors++;
                $display("FAIL midload_write: addr=%h data=%h required 00000000/cafef00d", aw_q[0], w_q[0]);
            end
        end
        checks++;
        if (boot_done !== 1'b1 || words_written !== 10'd1 || cpu_resetn !== 1'b1) begin
            errors++;
            $display("FAIL midload_status: done=%b ww=%0d cpu_rstn=%b required 1/1/1", boot_done, words_written, cpu_resetn);
        end
    endtask

    initial begin
        resetn        = 1'b0;
        s_byte_valid  = 1'b0;
        s_byte_data   = 8'h00;
        m_axi_awready = 1'b0;
        m_axi_wready  = 1'b0;
        m_axi_bvalid  = 1'b0;
        m_axi_bresp   = 2'b00;
        test_reset();
        test_image3(0, 0);
        test_image3(3, 0);
        test_image3(0, 3);
        test_zero_header();
        test_too_big();
        test_bresp_error();
        test_reset_midload();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
